// File: rtl/ifetch_pkg.sv
// Shared fetch-stage types and constants.
// Included by the fetch buffer and the fetch stage top.
package ifetch_pkg;

  localparam logic PCSel_4   = 1'b0;
  localparam logic PCSel_ALU = 1'b1;

  localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

  localparam logic [31:0] NOP_INSTR = {20'd0, 5'd0, OPCODE_OPIMM};

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    S_RUN,
    S_FLUSH,
    S_HALT
  } fetch_state_e;

endpackage

// File: rtl/ifetch_unit_fifo.sv
// Small synchronous FIFO with clear, used for the fetch buffer
// and for the in-order tag queue of issued PCs.
module fetch_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic [31:0],
  parameter int  CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  T              wdata,
  output T              rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T              mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata;
        wr_q        <= inc(wr_q);
      end
      if (do_pop) rd_q <= inc(rd_q);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign rdata = mem_q[rd_q];
  assign count = cnt_q;
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order imem
// requests, buffers responses and squashes wrong-path work.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR   = ifetch_pkg::NOP_INSTR,
  parameter int          BUF_DEPTH   = 2,
  parameter int          FLUSH_SLOTS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        PCSel_in,
  input  logic [31:0] target_in,
  input  logic        send_nops_in,
  input  logic        halt_in,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  output logic [31:0] Instr_out,
  output logic [31:0] PC_out,
  output logic        valid_out,
  output logic        halt_out
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int FW = $clog2(FLUSH_SLOTS + 2);

  fetch_state_e  state_q;
  logic [31:0]   pc_q, pcout_q;
  logic [CW-1:0] drop_q;
  logic [FW-1:0] flush_q;

  fetch_entry_t  head, wentry;
  logic [31:0]   tag_head;
  logic [CW-1:0] occ, out_cnt;
  logic          buf_full, buf_empty, tag_full, tag_empty;

  logic running, redir_req, misalign, do_halt, do_redir;
  logic credit, issue, resp, drop_now, push, pop;

  assign running   = (state_q != S_HALT);
  assign redir_req = (PCSel_in == PCSel_ALU) || send_nops_in;
  assign misalign  = (target_in[1:0] != 2'b00);
  assign do_halt   = running && (halt_in || (redir_req && misalign));
  assign do_redir  = running && redir_req && !do_halt;

  // occupancy plus outstanding is the credit that keeps pushes from overflowing
  assign credit = (int'(occ) + int'(out_cnt)) < BUF_DEPTH;
  assign issue  = running && !halt_in && !redir_req && credit && !tag_full;

  assign resp     = running && imem_rvalid && !tag_empty;
  assign drop_now = resp && (drop_q != '0);
  assign push     = resp && !drop_now && !do_redir && !do_halt;

  assign valid_out = !buf_empty && (state_q == S_RUN);
  assign pop       = valid_out && !stall_in && !do_redir && !do_halt;

  assign wentry = '{pc: tag_head, instr: imem_rdata};

  fetch_fifo #(.DEPTH(BUF_DEPTH), .T(fetch_entry_t)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .clear (do_redir || do_halt),
    .push  (push),
    .pop   (pop),
    .wdata (wentry),
    .rdata (head),
    .full  (buf_full),
    .empty (buf_empty),
    .count (occ)
  );

  fetch_fifo #(.DEPTH(BUF_DEPTH), .T(logic [31:0])) u_tag (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .push  (issue),
    .pop   (resp),
    .wdata (pc_q),
    .rdata (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (out_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
      pcout_q <= RESET_PC;
      drop_q  <= '0;
      flush_q <= '0;
    end else if (do_halt) begin
      state_q <= S_HALT;
    end else if (do_redir) begin
      state_q <= (FLUSH_SLOTS == 0) ? S_RUN : S_FLUSH;
      pc_q    <= target_in;
      pcout_q <= target_in;
      drop_q  <= out_cnt - CW'(resp);
      flush_q <= FW'(FLUSH_SLOTS);
    end else begin
      if (issue) pc_q <= pc_q + 32'd4;
      if (pop) pcout_q <= head.pc;
      if (drop_now) drop_q <= drop_q - 1'b1;
      if (state_q == S_FLUSH && !stall_in) begin
        flush_q <= flush_q - 1'b1;
        if (flush_q <= FW'(1)) state_q <= S_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push && !pop) assert (!buf_full);
  end

  assign imem_req  = issue && !rst;
  assign imem_addr = pc_q;
  assign Instr_out = valid_out ? head.instr : NOP_INSTR;
  assign PC_out    = valid_out ? head.pc : pcout_q;
  assign halt_out  = (state_q == S_HALT);

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomised bench for ifetch_unit with a queue-based reference
// model, an in-order variable-latency memory and directed pins.
module tb_ifetch_unit;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          DEPTH = 2;
  localparam int          SLOTS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_in = 1'b0;
  logic        PCSel_in = 1'b0;
  logic        send_nops_in = 1'b0;
  logic        halt_in = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] target_in = '0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req, valid_out, halt_out;
  logic [31:0] imem_addr, Instr_out, PC_out;

  always #5 clk = ~clk;

  ifetch_unit #(
    .RESET_PC    (32'h0),
    .NOP_INSTR   (NOP),
    .BUF_DEPTH   (DEPTH),
    .FLUSH_SLOTS (SLOTS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_in     (stall_in),
    .PCSel_in     (PCSel_in),
    .target_in    (target_in),
    .send_nops_in (send_nops_in),
    .halt_in      (halt_in),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_rvalid  (imem_rvalid),
    .Instr_out    (Instr_out),
    .PC_out       (PC_out),
    .valid_out    (valid_out),
    .halt_out     (halt_out)
  );

  int n_vec = 0;
  int n_err = 0;

  logic        rst_v = 1'b1, stall_v = 1'b0, redir_v = 1'b0, halt_v = 1'b0;
  logic [31:0] tgt_v = '0;
  bit          redir_on_rv = 0;
  int          lat_min = 1, lat_max = 1;

  typedef struct {
    logic [31:0] addr;
    longint      due;
  } mreq_t;
  mreq_t  mq[$];
  longint cyc = 0;
  longint last_due = 0;

  // reference model: RUN=0, FLUSH=1, HALTED=2
  int          m_mode, m_drop, m_flush;
  logic [31:0] m_pc, m_pcout;
  logic [63:0] m_buf[$];
  logic [31:0] m_tags[$];

  logic [31:0] vlog[$];
  logic [31:0] ilog[$];
  int          rcyc = 0;
  int          first_valid = -1;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] vat(input int i);
    if (i < vlog.size()) return vlog[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] iat(input int i);
    if (i < ilog.size()) return ilog[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_drop  = 0;
    m_flush = 0;
    m_pc    = 32'h0;
    m_pcout = 32'h0;
    m_buf.delete();
    m_tags.delete();
  endtask

  task automatic step();
    logic        rv, hooked, redir, e_req, e_val, resp;
    logic [31:0] rd, e_ins, e_pc, tag;
    longint      due;
    @(negedge clk);
    rv = 1'b0;
    rd = $urandom;
    hooked = 1'b0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      rv = 1'b1;
      rd = memfn(mq[0].addr);
      void'(mq.pop_front());
    end
    if (redir_on_rv && rv && !rst_v) begin
      redir_v = 1'b1;
      redir_on_rv = 0;
      hooked = 1'b1;
    end
    rst = rst_v;
    stall_in = stall_v;
    PCSel_in = redir_v;
    send_nops_in = redir_v;
    target_in = tgt_v;
    halt_in = halt_v;
    imem_rvalid = rv;
    imem_rdata = rd;
    #1;
    redir = redir_v;
    e_val = (m_mode == 0) && (m_buf.size() > 0);
    e_ins = e_val ? m_buf[0][31:0] : NOP;
    e_pc  = e_val ? m_buf[0][63:32] : m_pcout;
    e_req = !rst_v && (m_mode != 2) && !halt_v && !redir &&
            (m_buf.size() + m_tags.size() < DEPTH);
    chk("imem_req", imem_req, e_req);
    if (!rst_v) begin
      if (e_req) chk("imem_addr", imem_addr, m_pc);
      chk("valid_out", valid_out, e_val);
      chk("Instr_out", Instr_out, e_ins);
      chk("halt_out", halt_out, m_mode == 2);
      if (e_val || m_mode == 1) chk("PC_out", PC_out, e_pc);
    end
    if (imem_req) begin
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq.push_back('{addr: imem_addr, due: due});
      if (!rst_v) ilog.push_back(imem_addr);
    end
    if (!rst_v && valid_out && !stall_in) vlog.push_back(PC_out);
    if (!rst_v && valid_out && first_valid < 0) first_valid = rcyc;
    if (!rst_v && redir) vlog.delete();
    // model next state
    if (rst_v) begin
      model_reset();
    end else if (m_mode != 2) begin
      resp = rv && (m_tags.size() > 0);
      if (halt_v || (redir && tgt_v[1:0] != 2'b00)) begin
        m_mode = 2;
      end else begin
        if (resp) begin
          tag = m_tags.pop_front();
          if (m_drop > 0) m_drop--;
          else if (!redir) m_buf.push_back({tag, rd});
        end
        if (redir) begin
          m_buf.delete();
          m_drop  = m_tags.size();
          m_pc    = tgt_v;
          m_pcout = tgt_v;
          m_flush = SLOTS;
          m_mode  = 1;
        end else begin
          if (e_val && !stall_v) begin
            m_pcout = m_buf[0][63:32];
            void'(m_buf.pop_front());
          end
          if (e_req) begin
            m_tags.push_back(m_pc);
            m_pc = m_pc + 32'd4;
          end
          if (m_mode == 1 && !stall_v) begin
            m_flush--;
            if (m_flush == 0) m_mode = 0;
          end
        end
      end
    end
    rcyc = rst_v ? 0 : rcyc + 1;
    cyc++;
    if (hooked) redir_v = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input int n);
    rst_v = 1'b1;
    stall_v = 1'b0;
    redir_v = 1'b0;
    halt_v = 1'b0;
    redir_on_rv = 0;
    run(n);
    for (int i = 0; i < 12 && mq.size() > 0; i++) step();
    chk("rst_mem_drain", mq.size(), 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_Instr_out", Instr_out, NOP);
    chk("rst_PC_out", PC_out, 32'h0);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_halt_out", halt_out, 0);
    rst_v = 1'b0;
    vlog.delete();
    ilog.delete();
    first_valid = -1;
  endtask

  initial begin
    int reqs;
    model_reset();

    // 1: latency 1, no stall
    lat_min = 1;
    lat_max = 1;
    do_reset(3);
    run(8);
    chk("t1_issue0", iat(0), 32'h0);
    chk("t1_issue1", iat(1), 32'h4);
    chk("t1_issue2", iat(2), 32'h8);
    chk("t1_first_valid_cycle", first_valid, 2);
    chk("t1_pc0", vat(0), 32'h0);
    chk("t1_pc1", vat(1), 32'h4);
    chk("t1_pc2", vat(2), 32'h8);

    // 2: five stalled cycles
    stall_v = 1'b1;
    reqs = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (imem_req) reqs++;
    end
    chk("t2_stall_req_bound", reqs <= DEPTH, 1);
    stall_v = 1'b0;
    run(10);
    for (int i = 1; i < vlog.size(); i++)
      chk("t2_pc_seq", vlog[i], vlog[i-1] + 32'd4);

    // 3: redirect with responses in flight
    lat_min = 3;
    lat_max = 3;
    run(6);
    tgt_v = 32'h100;
    redir_v = 1'b1;
    step();
    redir_v = 1'b0;
    chk("t3_flush_valid", valid_out, 0);
    run(12);
    chk("t3_pc0", vat(0), 32'h100);
    chk("t3_pc1", vat(1), 32'h104);

    // 4: redirect coincident with a response, then under stall
    lat_min = 2;
    lat_max = 2;
    tgt_v = 32'h200;
    redir_on_rv = 1;
    for (int i = 0; i < 12 && redir_on_rv; i++) step();
    chk("t4_rv_redirect_seen", redir_on_rv, 0);
    redir_on_rv = 0;
    run(10);
    chk("t4_pc0", vat(0), 32'h200);
    chk("t4_pc1", vat(1), 32'h204);
    stall_v = 1'b1;
    tgt_v = 32'h300;
    redir_v = 1'b1;
    step();
    redir_v = 1'b0;
    run(2);
    stall_v = 1'b0;
    run(10);
    chk("t4_stall_pc0", vat(0), 32'h300);
    chk("t4_stall_pc1", vat(1), 32'h304);

    // 5: halt pulse, then misaligned redirect
    halt_v = 1'b1;
    step();
    halt_v = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_halt_out", halt_out, 1);
      chk("t5_req", imem_req, 0);
      chk("t5_valid", valid_out, 0);
    end
    do_reset(3);
    run(6);
    tgt_v = 32'h102;
    redir_v = 1'b1;
    step();
    redir_v = 1'b0;
    step();
    chk("t5_misalign_halt", halt_out, 1);

    // 6: reset with requests in flight, then PC wrap
    do_reset(3);
    lat_min = 3;
    lat_max = 3;
    run(5);
    do_reset(2);
    run(10);
    chk("t6_first_pc", vat(0), 32'h0);
    lat_min = 1;
    lat_max = 1;
    tgt_v = 32'hFFFF_FFF8;
    redir_v = 1'b1;
    step();
    redir_v = 1'b0;
    run(16);
    chk("t6_wrap0", vat(0), 32'hFFFF_FFF8);
    chk("t6_wrap1", vat(1), 32'hFFFF_FFFC);
    chk("t6_wrap2", vat(2), 32'h0);
    chk("t6_wrap3", vat(3), 32'h4);
    chk("t6_no_halt", halt_out, 0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) begin
        lat_min = 1;
        lat_max = $urandom_range(4, 1);
      end
      stall_v = ($urandom % 100) < 30;
      redir_v = ($urandom % 100) < 5;
      if ($urandom % 8 == 0) tgt_v = 32'hFFFF_FFF0 | ($urandom & 32'hC);
      else tgt_v = $urandom & 32'h0000_0FFC;
      if ($urandom % 300 == 0) tgt_v[0] = 1'b1;
      halt_v = ($urandom % 700) == 0;
      step();
      if (m_mode == 2) begin
        halt_v = 1'b0;
        redir_v = 1'b0;
        run(3);
        do_reset($urandom_range(3, 1));
      end
    end
    halt_v = 1'b0;
    redir_v = 1'b0;
    stall_v = 1'b0;
    run(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
